// File: rtl/fsrc_rx_pkg.sv
// Shared types and width helper for the FSRC RX hole generator.
// Used by fsrc_rx_phase_carry and fsrc_rx_hole_gen.
package fsrc_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2
   } state_t;

   // How the mask of a beat is formed once it reaches the output stage
   typedef enum logic [1:0] {
      MODE_DROP = 2'd0,
      MODE_KEEP = 2'd1,
      MODE_CALC = 2'd2
   } beat_mode_t;

   function automatic int sum_width(input int acc_width, input int num_words);
      return acc_width + $clog2(num_words + 1);
   endfunction

endpackage

// File: rtl/fsrc_rx_phase_carry.sv
// Combinational phase stepping: from start phase a and step, produce the per-word hole mask
// (no carry out of the accumulator width -> hole) and the wrapped phase after the beat.
module fsrc_rx_phase_carry
   import fsrc_rx_pkg::*;
#(
   parameter int ACC_WIDTH = 16,
   parameter int NUM_WORDS = 4
) (
   input  logic [ACC_WIDTH-1:0] a,
   input  logic [ACC_WIDTH-1:0] step,
   output logic [NUM_WORDS-1:0] holes,
   output logic [ACC_WIDTH-1:0] next_acc
);

   localparam int SW = sum_width(ACC_WIDTH, NUM_WORDS);
   localparam int CW = SW - ACC_WIDTH;

   logic [SW-1:0] sum_s [0:NUM_WORDS];

   // Running sums s_k = a + (k+1)*step; a word is kept when the integer part advances
   always_comb begin
      sum_s[0] = {{CW{1'b0}}, a};
      holes    = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         sum_s[k+1] = sum_s[k] + {{CW{1'b0}}, step};
         holes[k]   = !(sum_s[k+1][SW-1:ACC_WIDTH] > sum_s[k][SW-1:ACC_WIDTH]);
      end
      next_acc = sum_s[NUM_WORDS][ACC_WIDTH-1:0];
   end

endmodule

// File: rtl/fsrc_rx_hole_gen.sv
// FSRC RX hole-mask generator feeding fill_holes; data/valid delayed 2 cycles to match the mask.
// Optional status counters enabled with FSRC_RX_HOLE_GEN_STATUS_EN.
module fsrc_rx_hole_gen
   import fsrc_rx_pkg::*;
#(
   parameter int WORD_LENGTH = 16,
   parameter int NUM_WORDS   = 4,
   parameter int ACC_WIDTH   = 16
) (
   input  logic                             clk,
   input  logic                             resetn,
   input  logic [ACC_WIDTH-1:0]             cfg_step,
   input  logic [ACC_WIDTH-1:0]             cfg_init,
   input  logic                             cfg_bypass,
   input  logic                             start,
   input  logic                             stop,
   input  logic [WORD_LENGTH*NUM_WORDS-1:0] in_data,
   input  logic                             in_valid,
   output logic [WORD_LENGTH*NUM_WORDS-1:0] out_data,
   output logic                             out_valid,
   output logic [NUM_WORDS-1:0]             out_holes,
   output logic                             running
`ifdef FSRC_RX_HOLE_GEN_STATUS_EN
   ,
   output logic [31:0]                      kept_cnt,
   output logic [31:0]                      beat_cnt
`endif
);

   localparam int DW = WORD_LENGTH * NUM_WORDS;

   state_t                 state_r;
   state_t                 next_state_s;
   logic                   running_r;

   beat_mode_t             mode_s;
   logic [ACC_WIDTH-1:0]   a_sel_s;
   logic [ACC_WIDTH-1:0]   acc_r;
   logic [ACC_WIDTH-1:0]   acc_eff_s;

   logic                   s1_valid_r;
   logic [DW-1:0]          s1_data_r;
   logic [ACC_WIDTH-1:0]   s1_a_r;
   logic [ACC_WIDTH-1:0]   s1_step_r;
   beat_mode_t             s1_mode_r;

   logic [NUM_WORDS-1:0]   holes_s;
   logic [ACC_WIDTH-1:0]   next_acc_s;

   logic                   out_valid_r;
   logic [DW-1:0]          out_data_r;
   logic [NUM_WORDS-1:0]   out_holes_r;

   // State register; running mirrors the RUN state from a flop
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= IDLE;
         running_r <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         running_r <= (next_state_s == RUN);
      end
   end

   // Next state: stop beats start, start re-arms from any state
   always_comb begin
      next_state_s = state_r;
      if (stop) begin
         next_state_s = IDLE;
      end else if (start) begin
         next_state_s = ARMED;
      end else begin
         case (state_r)
            IDLE:    next_state_s = IDLE;
            ARMED:   next_state_s = in_valid ? RUN : ARMED;
            RUN:     next_state_s = RUN;
            default: next_state_s = IDLE;
         endcase
      end
   end

   // A beat still in stage 1 has not yet committed its phase, so forward it
   assign acc_eff_s = (s1_valid_r && (s1_mode_r == MODE_CALC)) ? next_acc_s : acc_r;

   // Beat mode and start phase for the incoming beat
   always_comb begin
      mode_s  = MODE_DROP;
      a_sel_s = acc_eff_s;
      if (cfg_bypass) begin
         mode_s = MODE_KEEP;
      end else if (state_r == IDLE) begin
         mode_s = MODE_DROP;
      end else begin
         mode_s = MODE_CALC;
      end
      if (state_r == ARMED) begin
         a_sel_s = cfg_init;
      end else begin
         a_sel_s = acc_eff_s;
      end
   end

   // Stage 1: capture beat, start phase and step
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid_r <= 1'b0;
         s1_data_r  <= '0;
         s1_a_r     <= '0;
         s1_step_r  <= '0;
         s1_mode_r  <= MODE_DROP;
      end else begin
         s1_valid_r <= in_valid;
         s1_data_r  <= in_data;
         s1_a_r     <= a_sel_s;
         s1_step_r  <= cfg_step;
         s1_mode_r  <= mode_s;
      end
   end

   fsrc_rx_phase_carry #(
      .ACC_WIDTH (ACC_WIDTH),
      .NUM_WORDS (NUM_WORDS)
   ) u_phase_carry (
      .a        (s1_a_r),
      .step     (s1_step_r),
      .holes    (holes_s),
      .next_acc (next_acc_s)
   );

   // Accumulator commits only for computed valid beats
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_r <= '0;
      end else if (s1_valid_r && (s1_mode_r == MODE_CALC)) begin
         acc_r <= next_acc_s;
      end else begin
         acc_r <= acc_r;
      end
   end

   // Stage 2: registered mask and delayed beat
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_holes_r <= '1;
      end else begin
         out_valid_r <= s1_valid_r;
         out_data_r  <= s1_data_r;
         case (s1_mode_r)
            MODE_DROP: out_holes_r <= '1;
            MODE_KEEP: out_holes_r <= '0;
            MODE_CALC: out_holes_r <= holes_s;
            default:   out_holes_r <= '1;
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_holes = out_holes_r;
   assign running   = running_r;

`ifdef FSRC_RX_HOLE_GEN_STATUS_EN
   logic [31:0] kept_cnt_r;
   logic [31:0] beat_cnt_r;
   logic [31:0] kept_now_s;

   // Number of kept words in the beat leaving stage 2
   always_comb begin
      kept_now_s = 32'd0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         kept_now_s = kept_now_s + {31'd0, ~out_holes_r[k]};
      end
   end

   // Status counters: cleared by start, wrap naturally
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         kept_cnt_r <= 32'd0;
         beat_cnt_r <= 32'd0;
      end else if (start) begin
         kept_cnt_r <= 32'd0;
         beat_cnt_r <= 32'd0;
      end else if (out_valid_r) begin
         kept_cnt_r <= kept_cnt_r + kept_now_s;
         beat_cnt_r <= beat_cnt_r + 32'd1;
      end else begin
         kept_cnt_r <= kept_cnt_r;
         beat_cnt_r <= beat_cnt_r;
      end
   end

   assign kept_cnt = kept_cnt_r;
   assign beat_cnt = beat_cnt_r;
`endif

endmodule

// File: tb/tb_fsrc_rx_hole_gen.sv
// Self-checking bench for fsrc_rx_hole_gen: directed steps plus random traffic
// compared against a word-by-word phase model.
module tb_fsrc_rx_hole_gen;

   localparam int WL = 16;
   localparam int NW = 4;
   localparam int AW = 16;
   localparam int S_IDLE  = 0;
   localparam int S_ARMED = 1;
   localparam int S_RUN   = 2;

   logic              clk = 1'b0;
   logic              resetn;
   logic [AW-1:0]     cfg_step;
   logic [AW-1:0]     cfg_init;
   logic              cfg_bypass;
   logic              start;
   logic              stop;
   logic [WL*NW-1:0]  in_data;
   logic              in_valid;
   logic [WL*NW-1:0]  out_data;
   logic              out_valid;
   logic [NW-1:0]     out_holes;
   logic              running;
`ifdef FSRC_RX_HOLE_GEN_STATUS_EN
   logic [31:0]       kept_cnt;
   logic [31:0]       beat_cnt;
`endif

   always #5 clk = ~clk;

   fsrc_rx_hole_gen #(.WORD_LENGTH(WL), .NUM_WORDS(NW), .ACC_WIDTH(AW)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .cfg_step   (cfg_step),
      .cfg_init   (cfg_init),
      .cfg_bypass (cfg_bypass),
      .start      (start),
      .stop       (stop),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_holes  (out_holes),
      .running    (running)
`ifdef FSRC_RX_HOLE_GEN_STATUS_EN
      ,
      .kept_cnt   (kept_cnt),
      .beat_cnt   (beat_cnt)
`endif
   );

   typedef struct {
      logic             valid;
      logic [WL*NW-1:0] data;
      logic [NW-1:0]    holes;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   int          m_state = S_IDLE;
   longint      m_acc = 0;
   exp_t        exp_prev;
   logic [NW-1:0] last_holes = '1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle, predict the beat, then compare outputs of the beat from the previous cycle
   task automatic step_cycle(input bit v, input bit st, input bit sp, input bit byp,
                             input logic [AW-1:0] stp, input logic [AW-1:0] ini);
      exp_t   e;
      longint a;
      in_valid   = v;
      start      = st;
      stop       = sp;
      cfg_bypass = byp;
      cfg_step   = stp;
      cfg_init   = ini;
      in_data    = {$urandom, $urandom};
      e.valid = v;
      e.data  = in_data;
      e.holes = '1;
      if (byp) begin
         e.holes = '0;
      end else if (m_state != S_IDLE) begin
         a = (m_state == S_ARMED) ? longint'(ini) : m_acc;
         for (int k = 0; k < NW; k++) begin
            a = a + longint'(stp);
            e.holes[k] = (a < 65536);
            a = a % 65536;
         end
         if (v) m_acc = a;
      end
      if (sp) m_state = S_IDLE;
      else if (st) m_state = S_ARMED;
      else if (m_state == S_ARMED && v) m_state = S_RUN;
      @(posedge clk);
      #1;
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_prev.valid});
      if (exp_prev.valid) begin
         check("out_data", out_data, exp_prev.data);
         check("out_holes", {60'd0, out_holes}, {60'd0, exp_prev.holes});
         last_holes = out_holes;
      end
      check("running", {63'd0, running}, {63'd0, (m_state == S_RUN)});
      exp_prev = e;
   endtask

   initial begin
      exp_prev = '{valid: 1'b0, data: '0, holes: '1};
      resetn = 1'b0; cfg_step = '0; cfg_init = '0; cfg_bypass = 1'b0;
      start = 1'b0; stop = 1'b0; in_data = '0; in_valid = 1'b0;
      #12;
      check("reset_valid", {63'd0, out_valid}, 64'd0);
      check("reset_holes", {60'd0, out_holes}, 64'hF);
      check("reset_running", {63'd0, running}, 64'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // 1: ratio 1/2
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h8000, 16'h0000);
      for (int i = 0; i < 8; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h8000, 16'h0000);
      check("t1_mask", {60'd0, last_holes}, 64'h5);

      // 2: ratio 3/4, re-armed from RUN
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'hC000, 16'h0000);
      for (int i = 0; i < 8; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'hC000, 16'h0000);
      check("t2_mask", {60'd0, last_holes}, 64'h1);

      // 3: ratio 1/3 for three beats
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000);
      for (int i = 0; i < 3; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0000);
      for (int i = 0; i < 2; i++) step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0000);

      // 4: bypass in IDLE, then in RUN with phase held across it
      step_cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h5555, 16'h0000);
      for (int i = 0; i < 3; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h0000);
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h1234);
      for (int i = 0; i < 4; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h1234);
      for (int i = 0; i < 3; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'h1234);
      for (int i = 0; i < 4; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h1234);

      // 5: gapped traffic, 1 on / 2 off
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h0000);
      for (int i = 0; i < 18; i++) step_cycle((i % 3) == 0, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0000);

      // 6: stop and start together land in IDLE
      step_cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h5555, 16'h0000);
      for (int i = 0; i < 4; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0000);
      check("t6_mask", {60'd0, last_holes}, 64'hF);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         step_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0,
                    $urandom_range(0, 40) == 0, $urandom_range(0, 15) == 0,
                    AW'($urandom), AW'($urandom));
      end

      // Async reset mid-run
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h3000, 16'h0000);
      for (int i = 0; i < 3; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0000);
      #3;
      resetn = 1'b0;
      #1;
      check("arst_valid", {63'd0, out_valid}, 64'd0);
      check("arst_running", {63'd0, running}, 64'd0);
      check("arst_holes", {60'd0, out_holes}, 64'hF);
      m_state = S_IDLE;
      m_acc = 0;
      exp_prev = '{valid: 1'b0, data: '0, holes: '1};
      @(posedge clk); #1;
      resetn = 1'b1;
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h3000, 16'h0100);
      for (int i = 0; i < 6; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0100);
      for (int i = 0; i < 3; i++) step_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h3000, 16'h0100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
